// File: rtl/serial_adder.sv
`default_nettype none
// serial_adder: bit-serial WIDTH-bit adder sequencing one full_adder slice, LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add the two's-complement overflow output.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic             past_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   left_sr;
   logic [WIDTH-1:0]   right_sr;
   logic [WIDTH-1:0]   sum_sr;
   logic [WIDTH:0]     sum_cat;
   logic               carry_q;
   logic [CNT_W-1:0]   count;
   logic               fa_s;
   logic               fa_c;
   logic               last_bit;
   logic               accept;

   full_adder u_fa (
      .a    (left_sr[0]),
      .b    (right_sr[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last_bit = (count == CNT_W'(WIDTH - 1));
   assign accept   = in_valid && in_ready;
   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
   assign sum_cat  = {fa_s, sum_sr};

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         left_sr  <= '0;
         right_sr <= '0;
         sum_sr   <= '0;
         carry_q  <= 1'b0;
         count    <= '0;
      end else if (accept) begin
         left_sr  <= left;
         right_sr <= right;
         carry_q  <= past_carry;
         count    <= '0;
      end else if (state == BUSY) begin
         left_sr  <= left_sr >> 1;
         right_sr <= right_sr >> 1;
         sum_sr   <= sum_cat[WIDTH:1];
         carry_q  <= fa_c;
         count    <= count + CNT_W'(1);
      end
   end

   assign sum   = sum_sr;
   assign carry = carry_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic ovf_q;

   // On the final bit, carry_q is the carry into the MSB and fa_c the carry out.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (state == BUSY && last_bit) begin
         ovf_q <= carry_q ^ fa_c;
      end
   end

   assign overflow = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// tb_serial_adder: directed checks of serial_adder (WIDTH=8 and WIDTH=1) against an arithmetic model.

module tb_serial_adder;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid, in_ready, past_carry, out_valid, out_ready, carry;
   logic [W-1:0] left, right, sum;
   logic         in_valid1, in_ready1, left1, right1, past_carry1, out_valid1, out_ready1, sum1, carry1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic         overflow, overflow1;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q[$];

   always #5 clock = ~clock;

   serial_adder #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .left(left), .right(right), .past_carry(past_carry), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .carry(carry)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .left(left1), .right(right1), .past_carry(past_carry1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .carry(carry1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .overflow(overflow1)
`endif
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      logic [W:0] t;
      exp_t       m;
      t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      m.s = t[W-1:0];
      m.c = t[W];
      m.o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle the result is presented it must match the oldest outstanding operation.
   always @(negedge clock) begin
      if (!reset && out_valid) begin
         if (q.size() == 0) begin
            check("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            check("model_sum", 32'(sum), 32'(q[0].s));
            check("model_carry", 32'(carry), 32'(q[0].c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
            check("model_overflow", 32'(overflow), 32'(q[0].o));
`endif
         end
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int hold, input bit junk, input bit has_lit,
                        input logic [W-1:0] lit_s, input logic lit_c, input logic lit_o);
      int n;
      left       = a;
      right      = b;
      past_carry = ci;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      q.push_back(model(a, b, ci));
      @(posedge clock); #1;
      if (junk) begin
         left       = ~a;
         right      = a ^ 8'h5A;
         past_carry = ~ci;
      end else begin
         in_valid = 1'b0;
      end
      for (int k = 0; k < W; k++) begin
         check("busy_no_valid", 32'(out_valid), 32'd0);
         check("busy_in_ready", 32'(in_ready), 32'd0);
         @(posedge clock); #1;
      end
      check("latency_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      if (has_lit) begin
         check("lit_sum", 32'(sum), 32'(lit_s));
         check("lit_carry", 32'(carry), 32'(lit_c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
         check("lit_overflow", 32'(overflow), 32'(lit_o));
`endif
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clock); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (q.size() > 0) q.delete(0);
      check("post_idle_ready", 32'(in_ready), 32'd1);
      check("post_idle_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] e1;
      reset = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; left = '0; right = '0; past_carry = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; left1 = 1'b0; right1 = 1'b0; past_carry1 = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("init_in_ready", 32'(in_ready), 32'd1);
      check("init_out_valid", 32'(out_valid), 32'd0);
      check("init_sum", 32'(sum), 32'd0);
      check("init_carry", 32'(carry), 32'd0);

      do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op(8'h3C, 8'h55, 1'b1, 5, 1'b0, 1'b1, 8'h92, 1'b0, 1'b1);
      do_op(8'h12, 8'h34, 1'b0, 1, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

      // Reset three cycles into an operation discards it.
      left = 8'hAA; right = 8'h77; past_carry = 1'b1; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_carry", 32'(carry), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      q.delete();
      #1;
      check("midrst_ready_after", 32'(in_ready), 32'd1);
      repeat (W + 2) @(posedge clock);
      #1;
      check("midrst_no_output", 32'(out_valid), 32'd0);
      do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
               1'($urandom), 1'b0, '0, 1'b0, 1'b0);
      end

      // WIDTH=1 instance, exhaustive over all operand/carry combinations.
      for (int i = 0; i < 8; i++) begin
         left1 = i[0]; right1 = i[1]; past_carry1 = i[2];
         in_valid1 = 1'b1;
         check("w1_ready", 32'(in_ready1), 32'd1);
         @(posedge clock); #1;
         in_valid1 = 1'b0;
         check("w1_busy", 32'(out_valid1), 32'd0);
         @(posedge clock); #1;
         check("w1_valid", 32'(out_valid1), 32'd1);
         e1 = {1'b0, left1} + {1'b0, right1} + {1'b0, past_carry1};
         check("w1_result", 32'({carry1, sum1}), 32'(e1));
`ifdef SERIAL_ADDER_OVERFLOW_EN
         check("w1_overflow", 32'(overflow1), 32'((left1 == right1) && (e1[0] != left1)));
`endif
         out_ready1 = 1'b1;
         @(posedge clock); #1;
         out_ready1 = 1'b0;
         check("w1_idle", 32'(out_valid1), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
